// File: rtl/gbf_flgwei_ctrl.sv
// rtl/gbf_flgwei_ctrl.sv - global-buffer flag/weight SRAM FIFO sequencer and single-port arbiter
// Optional conflict statistic counter enabled by defining GBFFLGWEI_CTRL_STAT_EN.
module gbf_flgwei_ctrl #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_valid,
    input  logic [SRAM_WIDTH-1:0]     wr_data,
    output logic                      wr_ready,
    output logic                      rd_valid,
    output logic [SRAM_WIDTH-1:0]     rd_data,
    input  logic                      rd_ready,
    output logic [SRAM_DEPTH_BIT-1:0] sram_addr_w,
    output logic [SRAM_DEPTH_BIT-1:0] sram_addr_r,
    output logic                      sram_write_en,
    output logic                      sram_read_en,
    output logic [SRAM_WIDTH-1:0]     sram_data_in,
    input  logic [SRAM_WIDTH-1:0]     sram_data_out,
    output logic [SRAM_DEPTH_BIT:0]   count,
    output logic                      empty,
    output logic                      full,
    output logic [15:0]               conflict_cnt
);

    localparam int DEPTH = 1 << SRAM_DEPTH_BIT;
    localparam logic [SRAM_DEPTH_BIT:0] DEPTH_CNT = DEPTH[SRAM_DEPTH_BIT:0];

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    grant_e                    last_grant, last_grant_nxt;
    logic [SRAM_DEPTH_BIT-1:0] wr_ptr, rd_ptr;
    logic [SRAM_DEPTH_BIT-1:0] addr_w_q, addr_r_q;
    logic [1:0]                buf_cnt;
    logic                      inflight;
    logic [SRAM_WIDTH-1:0]     buf_tail;
    logic [2:0]                occ;
    logic                      pop, write_elig, read_elig;
    logic                      grant_w, grant_r;

    assign pop        = rd_valid & rd_ready;
    assign occ        = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign write_elig = wr_valid & ~full;
    assign read_elig  = (count != '0) && (occ < 3'd2);

    assign empty         = (count == '0);
    assign full          = (count == DEPTH_CNT);
    assign rd_valid      = (buf_cnt != 2'd0);
    assign wr_ready      = grant_w;
    assign sram_write_en = grant_w;
    assign sram_read_en  = grant_r;
    assign sram_data_in  = wr_data;
    // Addresses hold their last driven value while the matching strobe is idle.
    assign sram_addr_w   = grant_w ? wr_ptr : addr_w_q;
    assign sram_addr_r   = grant_r ? rd_ptr : addr_r_q;

    always_comb begin
        grant_w        = 1'b0;
        grant_r        = 1'b0;
        last_grant_nxt = last_grant;
        if (!flush) begin
            if (write_elig && (!read_elig || last_grant == GRANT_READ)) begin
                grant_w        = 1'b1;
                last_grant_nxt = GRANT_WRITE;
            end else if (read_elig) begin
                grant_r        = 1'b1;
                last_grant_nxt = GRANT_READ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_READ;
            addr_w_q   <= '0;
            addr_r_q   <= '0;
        end else begin
            last_grant <= last_grant_nxt;
            if (grant_w) addr_w_q <= wr_ptr;
            if (grant_r) addr_r_q <= rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
            rd_data  <= '0;
            buf_tail <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (grant_w) wr_ptr <= wr_ptr + 1'b1;
            if (grant_r) rd_ptr <= rd_ptr + 1'b1;
            if (grant_w)      count <= count + 1'b1;
            else if (grant_r) count <= count - 1'b1;
            inflight <= grant_r;
            buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
            // Two-entry output queue: rd_data is the head, buf_tail the second slot.
            if (pop) begin
                if (buf_cnt == 2'd2) begin
                    rd_data <= buf_tail;
                    if (inflight) buf_tail <= sram_data_out;
                end else if (inflight) begin
                    rd_data <= sram_data_out;
                end
            end else if (inflight) begin
                if (buf_cnt == 2'd0) rd_data  <= sram_data_out;
                else                 buf_tail <= sram_data_out;
            end
        end
    end

`ifdef GBFFLGWEI_CTRL_STAT_EN
    logic        conflict;
    logic [15:0] conflict_q;

    assign conflict     = write_elig & read_elig & ~flush;
    assign conflict_cnt = conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 16'd0;
        end else if (conflict && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_gbf_flgwei_ctrl.sv
// tb/tb_gbf_flgwei_ctrl.sv - self-checking bench for gbf_flgwei_ctrl
module tb_gbf_flgwei_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, wr_valid, rd_ready;
    logic [27:0] wr_data;
    logic        wr_ready, rd_valid;
    logic [27:0] rd_data;
    logic [5:0]  sram_addr_w, sram_addr_r;
    logic        sram_write_en, sram_read_en;
    logic [27:0] sram_data_in;
    logic [27:0] sram_data_out = 28'd0;
    logic [6:0]  count;
    logic        empty, full;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    gbf_flgwei_ctrl #(.SRAM_DEPTH_BIT(6), .SRAM_WIDTH(28)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .sram_addr_w(sram_addr_w), .sram_addr_r(sram_addr_r),
        .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
        .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
        .count(count), .empty(empty), .full(full), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    logic [27:0] mem [64];
    always @(posedge clk) begin
        if (sram_write_en) mem[sram_addr_w] <= sram_data_in;
        if (sram_read_en)  sram_data_out <= mem[sram_addr_r];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [27:0] sb [$];
    int          pop_cnt = 0;
    logic        hold_q = 1'b0;
    logic [27:0] hold_data = 28'd0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_q = 1'b0;
        end else begin
            chk("strobe_excl", {31'd0, sram_write_en & sram_read_en}, 32'd0);
            if (hold_q) begin
                chk("hold_valid", {31'd0, rd_valid}, 32'd1);
                chk("hold_data", {4'd0, rd_data}, {4'd0, hold_data});
            end
            if (wr_valid && wr_ready) sb.push_back(wr_data);
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) chk("sb_underflow", {4'd0, rd_data}, 32'hFFFFFFFF);
                else chk("order", {4'd0, rd_data}, {4'd0, sb.pop_front()});
                pop_cnt++;
            end
            hold_q    = rd_valid && !rd_ready && !flush;
            hold_data = rd_data;
            if (flush) sb.delete();
        end
    end

    typedef struct packed {
        logic        wv;
        logic [27:0] wd;
        logic        rr;
        logic        e_wrdy;
        logic        e_we;
        logic        e_re;
        logic [5:0]  e_aw;
        logic [5:0]  e_ar;
        logic [6:0]  e_cnt;
        logic        e_rv;
        logic [27:0] e_rd;
    } vec_t;

    vec_t tv [13];

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 28'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int  quiet;
        bit  done;
        wr_valid = 1'b0; rd_ready = 1'b1; quiet = 0; done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (!rd_valid && empty) quiet++; else quiet = 0;
            if (quiet >= 3) done = 1'b1;
            @(posedge clk); #1;
        end
        chk({name, "_drain_done"}, {31'd0, done}, 32'd1);
    endtask

    int n, stall, run, lat;

    initial begin
        // cycle-by-cycle trace from reset: first conflict follows a read grant, so write wins it
        tv = '{
            '{1'b1, 28'd1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 7'd0, 1'b0, 28'd0},
            '{1'b0, 28'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 7'd1, 1'b0, 28'd0},
            '{1'b1, 28'd2, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 6'd0, 7'd0, 1'b0, 28'd0},
            '{1'b0, 28'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd1, 7'd1, 1'b1, 28'd1},
            '{1'b1, 28'd3, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 6'd0, 7'd0, 1'b1, 28'd1},
            '{1'b1, 28'd4, 1'b0, 1'b1, 1'b1, 1'b0, 6'd3, 6'd0, 7'd1, 1'b1, 28'd1},
            '{1'b0, 28'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd2, 7'd2, 1'b1, 28'd1},
            '{1'b1, 28'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd4, 6'd0, 7'd1, 1'b1, 28'd2},
            '{1'b0, 28'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd3, 7'd2, 1'b1, 28'd3},
            '{1'b1, 28'd6, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5, 6'd0, 7'd1, 1'b0, 28'd0},
            '{1'b1, 28'd7, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd4, 7'd2, 1'b1, 28'd4},
            '{1'b1, 28'd7, 1'b0, 1'b1, 1'b1, 1'b0, 6'd6, 6'd0, 7'd1, 1'b1, 28'd4},
            '{1'b0, 28'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 7'd2, 1'b1, 28'd4}
        };

        do_reset();
        @(negedge clk);
        chk("rst_count", {25'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {4'd0, rd_data}, 32'd0);
        chk("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        chk("rst_strobes", {30'd0, sram_write_en, sram_read_en}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            wr_valid = tv[i].wv; wr_data = tv[i].wd; rd_ready = tv[i].rr;
            @(negedge clk);
            chk($sformatf("tv%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, tv[i].e_wrdy});
            chk($sformatf("tv%0d_we", i), {31'd0, sram_write_en}, {31'd0, tv[i].e_we});
            chk($sformatf("tv%0d_re", i), {31'd0, sram_read_en}, {31'd0, tv[i].e_re});
            chk($sformatf("tv%0d_count", i), {25'd0, count}, {25'd0, tv[i].e_cnt});
            chk($sformatf("tv%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, tv[i].e_rv});
            if (tv[i].e_we) chk($sformatf("tv%0d_addr_w", i), {26'd0, sram_addr_w}, {26'd0, tv[i].e_aw});
            if (tv[i].e_re) chk($sformatf("tv%0d_addr_r", i), {26'd0, sram_addr_r}, {26'd0, tv[i].e_ar});
            if (tv[i].e_rv) chk($sformatf("tv%0d_rd_data", i), {4'd0, rd_data}, {4'd0, tv[i].e_rd});
            @(posedge clk); #1;
        end
        @(negedge clk);
`ifdef GBFFLGWEI_CTRL_STAT_EN
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd3);
`else
        chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        drain("table");

        // fill until the SRAM holds a full DEPTH behind two buffered words
        do_reset();
        rd_ready = 1'b0; wr_valid = 1'b1; n = 0; stall = 0; wr_data = 28'h100;
        for (int cyc = 0; cyc < 400 && stall < 5; cyc++) begin
            @(negedge clk);
            if (wr_ready) begin n++; stall = 0; end else stall++;
            @(posedge clk); #1;
            wr_data = 28'h100 + 28'(n);
        end
        @(negedge clk);
        chk("fill_accepted", n, 32'd66);
        chk("fill_count", {25'd0, count}, 32'd64);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_empty", {31'd0, empty}, 32'd0);
        chk("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("fill_we", {31'd0, sram_write_en}, 32'd0);
        chk("fill_rd_data", {4'd0, rd_data}, 32'h100);
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_ready = 1'b1; run = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (rd_valid) run++;
            else if (run > 0) break;
        end
        chk("drain_run", run, 32'd66);
        chk("drain_count", {25'd0, count}, 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        @(posedge clk); #1;

        // 200 words streaming, write pointer wraps
        pop_cnt = 0; n = 0; wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 28'($urandom);
        for (int cyc = 0; cyc < 3000 && n < 200; cyc++) begin
            @(negedge clk);
            if (wr_ready) n++;
            @(posedge clk); #1;
            wr_data = 28'($urandom);
        end
        drain("stream");
        chk("stream_pops", pop_cnt, 32'd200);

        // random backpressure over 500 words
        pop_cnt = 0; n = 0;
        for (int cyc = 0; cyc < 8000 && n < 500; cyc++) begin
            wr_valid = ($urandom_range(3) != 0);
            rd_ready = $urandom_range(1) != 0;
            wr_data  = 28'($urandom);
            @(negedge clk);
            if (wr_valid && wr_ready) n++;
            @(posedge clk); #1;
        end
        drain("random");
        chk("random_pops", pop_cnt, 32'd500);

        // flush with count=5 and a read in flight
        do_reset();
        rd_ready = 1'b0; wr_valid = 1'b1; n = 0; wr_data = 28'h200;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            @(negedge clk);
            if (wr_ready) n++;
            @(posedge clk); #1;
            wr_data = 28'h200 + 28'(n);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("pre_flush_count", {25'd0, count}, 32'd6);
        chk("pre_flush_head", {4'd0, rd_data}, 32'h200);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        @(negedge clk);
        chk("pre_flush_read", {31'd0, sram_read_en}, 32'd1);
        @(posedge clk); #1;
        rd_ready = 1'b0; flush = 1'b1; wr_valid = 1'b1; wr_data = 28'h333;
        @(negedge clk);
        chk("flush_cycle_count", {25'd0, count}, 32'd5);
        chk("flush_cycle_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("flush_cycle_strobes", {30'd0, sram_write_en, sram_read_en}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_count", {25'd0, count}, 32'd0);
        chk("post_flush_empty", {31'd0, empty}, 32'd1);
        chk("post_flush_rd_valid", {31'd0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 28'hABCDEF0; rd_ready = 1'b1;
        @(negedge clk);
        chk("post_flush_wr_ready", {31'd0, wr_ready}, 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0; lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rd_valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        chk("write_to_valid_latency", lat, 32'd3);
        chk("post_flush_first_word", {4'd0, rd_data}, 32'hABCDEF0);
        @(posedge clk); #1;
        drain("post_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
